// File: rtl/ysyx_23060096_wbu.sv
// Memory-access / writeback stage: one instruction in flight, single-beat loads/stores, rf write + commit.
// Optional YSYX_23060096_WBU_MISALIGN_TRAP_EN: misaligned loads/stores skip memory and retire with misalign=1.
module ysyx_23060096_wbu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_sdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              commit
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q, ld_q, st_q, mis_q, mis_d;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   res_q, sdata_q;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              in_mis, wb_write;
    logic [4:0]        lane_sh;
    logic [XLEN-1:0]   ld_shift, ld_data;
    logic [3:0]        st_mask;

`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
    assign in_mis   = (in_is_load || in_is_store) &&
                      ((in_funct3[1:0] == 2'b01 && in_result[0]) ||
                       (in_funct3[1:0] == 2'b10 && in_result[1:0] != 2'b00));
    assign misalign = (state_q == WB) && mis_q;
`else
    assign in_mis   = 1'b0;
`endif

    assign lane_sh  = {res_q[1:0], 3'b000};
    assign ld_shift = mem_rdata >> lane_sh;

    always_comb begin
        case (f3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Masks shifted past lane 3 fall off the 4-bit vector (misaligned truncation).
    always_comb begin
        case (f3_q[1:0])
            2'b00:   st_mask = 4'b0001 << res_q[1:0];
            2'b01:   st_mask = 4'b0011 << res_q[1:0];
            default: st_mask = 4'b1111;
        endcase
    end

    assign wb_write  = wen_q && !st_q && (rd_q != '0) && !mis_q;

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && st_q;
    assign mem_addr  = mem_req ? {res_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? (sdata_q << lane_sh) : '0;
    assign mem_wmask = mem_req ? st_mask : '0;
    assign commit    = (state_q == WB);
    assign rf_wen    = commit && wb_write;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

    always_comb begin
        state_d    = state_q;
        mis_d      = mis_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            IDLE: begin
                mis_d = 1'b0;
                if (in_valid) begin
                    if (in_is_load || in_is_store) begin
                        if (in_mis) begin
                            state_d = WB;
                            mis_d   = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        state_d = WB;
                        if (in_wen && in_rd != '0) begin
                            rf_waddr_d = in_rd;
                            rf_wdata_d = in_result;
                        end
                    end
                end
            end
            REQ, WAIT: begin
                // gnt+rvalid together in REQ retires straight away.
                if ((state_q == WAIT || mem_gnt) && mem_rvalid) begin
                    state_d = WB;
                    if (wb_write) begin
                        rf_waddr_d = rd_q;
                        rf_wdata_d = ld_q ? ld_data : res_q;
                    end
                end else if (state_q == REQ && mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WB: begin
                state_d = IDLE;
                mis_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mis_q      <= 1'b0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            f3_q       <= '0;
            res_q      <= '0;
            sdata_q    <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mis_q      <= mis_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            if (state_q == IDLE && in_valid) begin
                rd_q    <= in_rd;
                wen_q   <= in_wen;
                ld_q    <= in_is_load;
                st_q    <= in_is_store;
                f3_q    <= in_funct3;
                res_q   <= in_result;
                sdata_q <= in_sdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Directed bench for ysyx_23060096_wbu: a behavioural retire/memory model checked every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_ysyx_23060096_wbu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, in_wen, in_is_load, in_is_store;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_result, in_sdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        rf_wen, commit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    ysyx_23060096_wbu #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rstn(rstn),
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_result(in_result), .in_sdata(in_sdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit(commit)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wen;
        logic [4:0]  a;
        logic [31:0] d;
        bit          mis;
    } ret_t;

    ret_t        expq[$];
    ret_t        e;
    logic        x_we;
    logic [31:0] x_addr, x_wdata;
    logic [3:0]  x_mask;
    logic [4:0]  held_a;
    logic [31:0] held_d;
    int          commits = 0;
    int          req_cycles = 0;
    logic        obs_wen;
    logic [31:0] obs_wdata, obs_maddr, obs_mwdata;
    logic [3:0]  obs_mmask;

    // ---- behavioural model ----
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
        int unsigned off = addr % 4;
        logic [31:0] v = w >> (8 * off);
        int s;
        case (f3)
            3'b000: begin s = int'(v % 256);   if (s >= 128)   s = s - 256;   return s; end
            3'b001: begin s = int'(v % 65536); if (s >= 32768) s = s - 65536; return s; end
            3'b100: return v % 256;
            3'b101: return v % 65536;
            default: return v;
        endcase
    endfunction

    function automatic bit is_mis(input bit mem, input logic [2:0] f3, input logic [31:0] addr);
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
        int unsigned off = addr % 4;
        return mem && ((f3 % 4 == 1 && off % 2 == 1) || (f3 % 4 == 2 && off != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (f3 % 4)
            0: return 4'((1 << off) % 16);
            1: return 4'((3 << off) % 16);
            default: return 4'hF;
        endcase
    endfunction

    // ---- compare process ----
    always @(negedge clk) begin
        if (!rstn) begin
            held_a = '0;
            held_d = '0;
        end else begin
            if (mem_req) begin
                req_cycles++;
                obs_maddr = mem_addr; obs_mwdata = mem_wdata; obs_mmask = mem_wmask;
                chk("mem_we", mem_we, x_we);
                chk("mem_addr", mem_addr, x_addr);
                chk("mem_wdata", mem_wdata, x_wdata);
                chk("mem_wmask", mem_wmask, x_mask);
            end
            if (commit) begin
                commits++;
                obs_wen = rf_wen; obs_wdata = rf_wdata;
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_commit: got commit=1 expected commit=0");
                end else begin
                    e = expq.pop_front();
                    chk("rf_wen", rf_wen, e.wen);
                    if (e.wen) begin held_a = e.a; held_d = e.d; end
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
                    chk("misalign", misalign, e.mis);
`endif
                end
            end else begin
                chk("rf_wen_quiet", rf_wen, 0);
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
                chk("misalign_quiet", misalign, 0);
`endif
            end
            chk("rf_waddr", rf_waddr, held_a);
            chk("rf_wdata", rf_wdata, held_d);
        end
    end

    // ---- driver ----
    task automatic op(input logic [4:0] rd, input bit wen, input bit ld, input bit st, input logic [2:0] f3,
                      input logic [31:0] res, input logic [31:0] sd, input logic [31:0] rdata,
                      input int gnt_dly, input int rv_dly, input bit same);
        int   c0 = commits;
        int   n = 0;
        bit   mis = is_mis(ld || st, f3, res);
        bit   mem = (ld || st) && !mis;
        ret_t r;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", in_ready, 1);
        r.wen = wen && !st && rd != 0 && !mis;
        r.a   = rd;
        r.d   = ld ? load_val(f3, res, rdata) : res;
        r.mis = mis;
        expq.push_back(r);
        x_we = st; x_addr = res - (res % 4); x_wdata = sd << (8 * (res % 4)); x_mask = st_mask(f3, res);
        in_rd = rd; in_wen = wen; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_result = res; in_sdata = sd; in_valid = 1'b1; req_cycles = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (mem) begin
            for (int i = 0; i < gnt_dly; i++) begin @(posedge clk); #1; end
            mem_gnt = 1'b1;
            if (same) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
            if (!same) begin
                for (int i = 0; i < rv_dly; i++) begin @(posedge clk); #1; end
                mem_rvalid = 1'b1; mem_rdata = rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
            end
        end
        @(posedge clk); #1;
        chk("commit_count", commits - c0, 1);
        chk("req_cycles", req_cycles, mem ? gnt_dly + 1 : 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rstn = 1'b0; in_valid = 0; in_rd = 0; in_wen = 0; in_is_load = 0; in_is_store = 0;
        in_funct3 = 0; in_result = 0; in_sdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_commit", commit, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        op(5, 1, 0, 0, 3'b000, 32'h12345678, 0, 0, 0, 0, 0);
        chk("alu_lit_wen", obs_wen, 1);
        chk("alu_lit_wdata", obs_wdata, 32'h12345678);
        op(0, 1, 0, 0, 3'b000, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        chk("x0_lit_wen", obs_wen, 0);
        op(7, 1, 1, 0, 3'b000, 32'h80000003, 0, 32'h80FF7F01, 2, 0, 0);
        chk("lb_lit_wdata", obs_wdata, 32'hFFFFFF80);
        chk("lb_lit_addr", obs_maddr, 32'h80000000);
        op(7, 1, 1, 0, 3'b100, 32'h80000003, 0, 32'h80FF7F01, 2, 0, 0);
        chk("lbu_lit_wdata", obs_wdata, 32'h00000080);
        op(3, 1, 0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 0, 0, 1, 0);
        chk("sh_lit_mask", obs_mmask, 4'b1100);
        chk("sh_lit_wdata", obs_mwdata, 32'hBEEF0000);
        chk("sh_lit_wen", obs_wen, 0);
        op(9, 1, 1, 0, 3'b001, 32'h80000102, 0, 32'h80017FFF, 0, 0, 0);
        chk("lh_lit_wdata", obs_wdata, 32'hFFFF8001);
        op(9, 1, 1, 0, 3'b101, 32'h80000102, 0, 32'h80017FFF, 1, 1, 0);
        op(10, 1, 1, 0, 3'b010, 32'h80000200, 0, 32'hCAFEF00D, 0, 3, 0);
        op(0, 0, 0, 1, 3'b000, 32'h80000001, 32'h000000A5, 0, 0, 0, 0);
        chk("sb_lit_mask", obs_mmask, 4'b0010);
        chk("sb_lit_wdata", obs_mwdata, 32'h0000A500);
        op(4, 0, 0, 1, 3'b010, 32'h80000300, 32'h01020304, 0, 0, 0, 1);
        op(11, 1, 1, 0, 3'b010, 32'h80000304, 0, 32'h55AA55AA, 1, 0, 1);
        op(12, 0, 1, 0, 3'b010, 32'h80000308, 0, 32'h11111111, 0, 0, 0);
        op(13, 1, 1, 0, 3'b001, 32'h80000003, 0, 32'h12345678, 0, 0, 0);
        op(14, 1, 1, 0, 3'b010, 32'h80000002, 0, 32'h12345678, 0, 0, 0);
`ifdef YSYX_23060096_WBU_MISALIGN_TRAP_EN
        chk("lw_mis_lit_wen", obs_wen, 0);
`else
        chk("lw_mis_lit_wdata", obs_wdata, 32'h00001234);
`endif

        // stale rvalid while idle
        c0 = commits;
        mem_rvalid = 1'b1; @(posedge clk); #1; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("stale_idle_commit", commits - c0, 0);

        // reset while waiting for read data
        c0 = commits;
        in_rd = 6; in_wen = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'b010;
        in_result = 32'h80000010; in_valid = 1'b1;
        x_we = 0; x_addr = 32'h80000010; x_wdata = 0; x_mask = 4'hF;
        @(posedge clk); #1; in_valid = 1'b0;
        mem_gnt = 1'b1; @(posedge clk); #1; mem_gnt = 1'b0;
        rstn = 1'b0; @(posedge clk); #1;
        rstn = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait_commit", commits - c0, 0);
        chk("rst_wait_ready", in_ready, 1);
        chk("rst_wait_waddr", rf_waddr, 0);

        op(8, 1, 0, 0, 3'b000, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
        chk("post_rst_wdata", obs_wdata, 32'hA5A5A5A5);
        chk("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
